// File: rtl/i2c_master_multi.sv
// Single-master I2C engine: START, 7-bit address, streamed write or read of up to
// 2^LEN_W-1 bytes with ACK checking and SCL stretching, STOP. Open-drain enables only.
module i2c_master_multi #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 4
) (
    input  logic             CLK_IW,
    input  logic             RST_N_IW,
    input  logic             START_IW,
    input  logic             RW_IW,
    input  logic [6:0]       ADDR_IW,
    input  logic [LEN_W-1:0] LEN_IW,
    input  logic [7:0]       TX_DATA_IW,
    output logic             TX_REQ_OW,
    output logic [7:0]       RX_DATA_OR,
    output logic             RX_VALID_OR,
    output logic             SCL_OE_OR,
    input  logic             SCL_IW,
    output logic             SDA_OE_OR,
    input  logic             SDA_IW,
    output logic             READY_OW,
    output logic             DONE_OR,
    output logic             NACK_OR
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_WRITE, S_ACK_W, S_READ, S_ACK_R, S_STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       q;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rw;
    logic [LEN_W-1:0] remaining;
    logic             sda_s;

    logic bit_state, stall, tick, pre_tick, go_write;

    assign bit_state = state inside {S_ADDR, S_ACK_A, S_WRITE, S_ACK_W, S_READ, S_ACK_R};
    // The quarter counter holds while we have released SCL but a slave keeps it low.
    assign stall     = !SCL_OE_OR && !SCL_IW &&
                       ((bit_state && q == 2'd2) || (state == S_STOP && q == 2'd1));
    assign tick      = (cnt == LAST) && !stall;
    assign pre_tick  = (cnt == PRE) && !stall;
    // Next bit is the MSB of a write byte: lets TX_REQ lead the consuming tick by one cycle.
    assign go_write  = (state == S_ACK_A || state == S_ACK_W) && !sda_s && !rw &&
                       (remaining != '0);
    assign READY_OW  = RST_N_IW && (state == S_IDLE);

    // NOTE: every register here is assigned with <= so all updates land together at the edge.
    always_ff @(posedge CLK_IW) begin
        if (!RST_N_IW) begin
            state       <= S_IDLE;
            cnt         <= '0;
            q           <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rw          <= 1'b0;
            remaining   <= '0;
            sda_s       <= 1'b0;
            SCL_OE_OR   <= 1'b0;
            SDA_OE_OR   <= 1'b0;
            TX_REQ_OW   <= 1'b0;
            RX_VALID_OR <= 1'b0;
            RX_DATA_OR  <= '0;
            DONE_OR     <= 1'b0;
            NACK_OR     <= 1'b0;
        end else begin
            TX_REQ_OW   <= pre_tick && (q == 2'd3) && go_write;
            RX_VALID_OR <= 1'b0;
            DONE_OR     <= 1'b0;
            if (state == S_IDLE) begin
                cnt <= '0;
                q   <= '0;
                if (START_IW) begin
                    rw        <= RW_IW;
                    shreg     <= {ADDR_IW, RW_IW};
                    remaining <= LEN_IW;
                    NACK_OR   <= 1'b0;
                    SDA_OE_OR <= 1'b1;
                    state     <= S_START;
                end
            end else begin
                if (!stall)
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                if (tick) begin
                    q <= q + 2'd1;
                    case (q)
                        2'd0: if (state == S_STOP) SCL_OE_OR <= 1'b0;
                        2'd1: begin
                            if (state == S_START)     SCL_OE_OR <= 1'b1;
                            else if (state == S_STOP) SDA_OE_OR <= 1'b0;
                            else                      SCL_OE_OR <= 1'b0;
                        end
                        2'd2: if (bit_state) begin
                            sda_s <= SDA_IW;
                            if (state == S_READ) shreg <= {shreg[6:0], SDA_IW};
                        end
                        default: begin
                            SCL_OE_OR <= 1'b1;
                            case (state)
                                S_START: begin
                                    state     <= S_ADDR;
                                    bit_idx   <= 3'd7;
                                    SDA_OE_OR <= !shreg[7];
                                end
                                S_ADDR, S_WRITE: begin
                                    if (bit_idx == 3'd0) begin
                                        state     <= (state == S_ADDR) ? S_ACK_A : S_ACK_W;
                                        SDA_OE_OR <= 1'b0;
                                        if (state == S_WRITE) remaining <= remaining - LEN_W'(1);
                                    end else begin
                                        bit_idx   <= bit_idx - 3'd1;
                                        shreg     <= {shreg[6:0], 1'b0};
                                        SDA_OE_OR <= !shreg[6];
                                    end
                                end
                                S_READ: begin
                                    if (bit_idx == 3'd0) begin
                                        state       <= S_ACK_R;
                                        RX_DATA_OR  <= shreg;
                                        RX_VALID_OR <= 1'b1;
                                        remaining   <= remaining - LEN_W'(1);
                                        SDA_OE_OR   <= (remaining != LEN_W'(1));
                                    end else begin
                                        bit_idx <= bit_idx - 3'd1;
                                    end
                                end
                                S_ACK_A, S_ACK_W: begin
                                    if (sda_s || remaining == '0) begin
                                        NACK_OR   <= NACK_OR | sda_s;
                                        state     <= S_STOP;
                                        SDA_OE_OR <= 1'b1;
                                    end else if (rw) begin
                                        state     <= S_READ;
                                        bit_idx   <= 3'd7;
                                        SDA_OE_OR <= 1'b0;
                                    end else begin
                                        state     <= S_WRITE;
                                        bit_idx   <= 3'd7;
                                        shreg     <= TX_DATA_IW;
                                        SDA_OE_OR <= !TX_DATA_IW[7];
                                    end
                                end
                                S_ACK_R: begin
                                    bit_idx   <= 3'd7;
                                    SDA_OE_OR <= (remaining == '0);
                                    state     <= (remaining == '0) ? S_STOP : S_READ;
                                end
                                S_STOP: begin
                                    state     <= S_IDLE;
                                    DONE_OR   <= 1'b1;
                                    SCL_OE_OR <= 1'b0;
                                    SDA_OE_OR <= 1'b0;
                                end
                                default: state <= S_IDLE;
                            endcase
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_multi.sv
// Directed bench for i2c_master_multi: open-drain bus with a behavioural slave,
// table-driven transactions plus stretch, reset and busy-START sequences.
module tb_i2c_master_multi;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       RST_N_IW = 1'b0;
    logic       START_IW = 1'b0;
    logic       RW_IW = 1'b0;
    logic [6:0] ADDR_IW = '0;
    logic [3:0] LEN_IW = '0;
    logic [7:0] TX_DATA_IW;
    logic       TX_REQ_OW, RX_VALID_OR, SCL_OE_OR, SDA_OE_OR, READY_OW, DONE_OR, NACK_OR;
    logic [7:0] RX_DATA_OR;
    logic       bus_scl, bus_sda;

    logic        hold = 1'b0;
    logic        slave_drv = 1'b0;
    logic        cfg_rw = 1'b0;
    logic        cfg_ack_addr = 1'b1;
    logic [23:0] cfg_bytes = '0;
    int          stretch_k = -1;
    logic        mon_clr = 1'b0;

    int   cyc = 0;
    int   nrise, start_seen, stop_seen, done_cnt, tx_cnt;
    logic bits [0:63];
    int   rise_t [0:63];
    logic [7:0] rxq [$];
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_txreq = 1'b0;
    event arm_ev;

    int n_checks = 0;
    int n_errors = 0;

    assign bus_scl    = !SCL_OE_OR && !hold;
    assign bus_sda    = !SDA_OE_OR && !slave_drv;
    assign TX_DATA_IW = (tx_cnt < 3) ? cfg_bytes[23 - 8*tx_cnt -: 8] : 8'h00;

    i2c_master_multi #(.CLK_DIV(D), .LEN_W(4)) dut (
        .CLK_IW(clk), .RST_N_IW(RST_N_IW), .START_IW(START_IW), .RW_IW(RW_IW),
        .ADDR_IW(ADDR_IW), .LEN_IW(LEN_IW), .TX_DATA_IW(TX_DATA_IW), .TX_REQ_OW(TX_REQ_OW),
        .RX_DATA_OR(RX_DATA_OR), .RX_VALID_OR(RX_VALID_OR), .SCL_OE_OR(SCL_OE_OR),
        .SCL_IW(bus_scl), .SDA_OE_OR(SDA_OE_OR), .SDA_IW(bus_sda), .READY_OW(READY_OW),
        .DONE_OR(DONE_OR), .NACK_OR(NACK_OR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave pull-down for bit k (counted from the address MSB).
    function automatic logic slave_bit(input int k);
        int j, b;
        if (k == 8) return cfg_ack_addr;
        if (k > 8) begin
            j = (k - 9) % 9;
            b = (k - 9) / 9;
            if (!cfg_rw) return (j == 8);
            if (j < 8 && b < 3) return !cfg_bytes[23 - 8*b - j];
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic cs, cd;
        cs = bus_scl;
        cd = bus_sda;
        if (mon_clr) begin
            nrise = 0; start_seen = 0; stop_seen = 0; done_cnt = 0; tx_cnt = 0;
            rxq.delete();
            slave_drv = 1'b0;
        end else begin
            if (cs && !prev_scl) begin
                if (nrise < 64) begin
                    bits[nrise]   = cd;
                    rise_t[nrise] = cyc;
                end
                nrise++;
            end
            if (!cs && prev_scl) begin
                slave_drv = slave_bit(nrise);
                if (nrise == stretch_k) -> arm_ev;
            end
            if (cs && prev_scl && prev_sda && !cd) start_seen++;
            if (cs && prev_scl && !prev_sda && cd) stop_seen++;
            if (DONE_OR) done_cnt++;
            if (RX_VALID_OR) rxq.push_back(RX_DATA_OR);
            if (prev_txreq && !TX_REQ_OW) tx_cnt++;
        end
        prev_scl   = cs;
        prev_sda   = cd;
        prev_txreq = TX_REQ_OW;
    end

    // Slave holds SCL low for 37 clocks after the master releases it.
    always begin
        @(arm_ev);
        hold = 1'b1;
        do @(negedge clk); while (SCL_OE_OR);
        repeat (37) @(posedge clk);
        #2 hold = 1'b0;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] get_byte(input int b);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], bits[9*b + i]};
        return v;
    endfunction

    task automatic start_xfer(input logic rw, input logic [6:0] addr, input logic [3:0] len);
        mon_clr = 1'b1;
        tick();
        tick();
        mon_clr  = 1'b0;
        RW_IW    = rw;
        ADDR_IW  = addr;
        LEN_IW   = len;
        START_IW = 1'b1;
        tick();
        START_IW = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (done_cnt != 0) break;
        end
        check({name, "_done_seen"}, int'(done_cnt != 0), 1);
        check({name, "_ready"}, int'(READY_OW), 1);
        repeat (20) tick();
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_stop"}, stop_seen, 1);
        check({name, "_start"}, start_seen, 1);
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [3:0]  len;
        logic        ack_addr;
        logic [23:0] data;
        logic [7:0]  exp_addr_byte;
        int          exp_clocks;
        int          exp_txreq;
        int          exp_rx;
        logic        exp_nack;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{1'b0, 7'h50, 4'd2, 1'b1, 24'hA53C00, 8'hA0, 27, 2, 0, 1'b0};
        vecs[1] = '{1'b1, 7'h3C, 4'd3, 1'b1, 24'h112233, 8'h79, 36, 0, 3, 1'b0};
        vecs[2] = '{1'b0, 7'h27, 4'd2, 1'b0, 24'hDEAD00, 8'h4E, 9,  0, 0, 1'b1};
        vecs[3] = '{1'b0, 7'h1A, 4'd0, 1'b1, 24'h000000, 8'h34, 9,  0, 0, 1'b0};

        repeat (3) tick();
        check("rst_scl_oe", int'(SCL_OE_OR), 0);
        check("rst_sda_oe", int'(SDA_OE_OR), 0);
        check("rst_outputs", int'({TX_REQ_OW, RX_VALID_OR, DONE_OR, NACK_OR}), 0);
        check("rst_rx_data", int'(RX_DATA_OR), 0);
        check("rst_ready_low", int'(READY_OW), 0);
        RST_N_IW = 1'b1;
        tick();
        check("ready_after_rst", int'(READY_OW), 1);

        for (int v = 0; v < 4; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            cfg_rw       = vecs[v].rw;
            cfg_ack_addr = vecs[v].ack_addr;
            cfg_bytes    = vecs[v].data;
            start_xfer(vecs[v].rw, vecs[v].addr, vecs[v].len);
            wait_done(tag);
            check({tag, "_addr_byte"}, int'(get_byte(0)), int'(vecs[v].exp_addr_byte));
            check({tag, "_scl_clocks"}, nrise - 1, vecs[v].exp_clocks);
            check({tag, "_tx_req"}, tx_cnt, vecs[v].exp_txreq);
            check({tag, "_nack"}, int'(NACK_OR), int'(vecs[v].exp_nack));
            check({tag, "_rx_count"}, rxq.size(), vecs[v].exp_rx);
            for (int b = 0; b < vecs[v].exp_txreq; b++)
                check({tag, $sformatf("_wbyte%0d", b)}, int'(get_byte(b + 1)),
                      int'(vecs[v].data[23 - 8*b -: 8]));
            for (int b = 0; b < vecs[v].exp_rx && b < rxq.size(); b++) begin
                check({tag, $sformatf("_rx%0d", b)}, int'(rxq[b]), int'(vecs[v].data[23 - 8*b -: 8]));
                check({tag, $sformatf("_mack%0d", b)}, int'(bits[9*(b + 1) + 8]),
                      int'(b == vecs[v].exp_rx - 1));
            end
        end

        // Stretch bit 3 of the single write byte (bit index 12 on the bus).
        cfg_rw = 1'b0; cfg_ack_addr = 1'b1; cfg_bytes = 24'h960000; stretch_k = 12;
        start_xfer(1'b0, 7'h2A, 4'd1);
        wait_done("stretch");
        stretch_k = -1;
        check("stretch_data", int'(get_byte(1)), 8'h96);
        check("stretch_clocks", nrise - 1, 18);
        check("stretch_pre_period", rise_t[11] - rise_t[10], 4*D);
        check("stretch_period", rise_t[12] - rise_t[11], 4*D + 37);
        check("stretch_post_period", rise_t[13] - rise_t[12], 4*D);

        // Reset in the middle of a read.
        cfg_rw = 1'b1; cfg_bytes = 24'h112233;
        start_xfer(1'b1, 7'h3C, 4'd3);
        repeat (200) tick();
        check("midread_busy", int'(READY_OW), 0);
        RST_N_IW = 1'b0;
        tick();
        check("midrst_oe", int'({SCL_OE_OR, SDA_OE_OR}), 0);
        RST_N_IW = 1'b1;
        tick();
        check("midrst_ready", int'(READY_OW), 1);
        repeat (300) tick();
        check("midrst_no_done", done_cnt, 0);
        check("midrst_scl_idle", int'(SCL_OE_OR), 0);

        // START while busy must be ignored.
        cfg_rw = 1'b0; cfg_bytes = 24'h5A0000;
        start_xfer(1'b0, 7'h50, 4'd1);
        repeat (60) tick();
        check("busy_ready", int'(READY_OW), 0);
        RW_IW = 1'b1; ADDR_IW = 7'h11; LEN_IW = 4'd3; START_IW = 1'b1;
        tick();
        START_IW = 1'b0;
        wait_done("busy");
        check("busy_addr_byte", int'(get_byte(0)), 8'hA0);
        check("busy_wbyte", int'(get_byte(1)), 8'h5A);
        check("busy_clocks", nrise - 1, 18);
        check("busy_tx_req", tx_cnt, 1);
        check("busy_rx_count", rxq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
